fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Instruction-fetch and beat-timing stage directly upstream of the decode stage.
- Holds the 16-bit PC and reads each 16-bit instruction word from instruction memory over a req/ack handshake.
- Latches the word into IR and generates the one-hot beat pulses T0..T3. Decode samples IR on the rising edge of T0.
- Takes PC redirects from the execute stage and stops on a HALT opcode.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
HALT_OPCODE, 5'b11111, IR[15:11] value that halts the sequencer

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
mem_rd  out  1  instruction read request
mem_addr  out  16  read address; always equals PC
mem_ack  in  1  read data valid on mem_rdata this cycle
mem_rdata  in  16  instruction word from memory
pc_load  in  1  redirect request from execute; sampled only in beat T3
pc_target  in  16  redirect address; sampled with pc_load
IR  out  16  current instruction register
PC  out  16  address of the current/next instruction
T0  out  1  beat 0 (decode strobe), high one cycle
T1  out  1  beat 1, high one cycle
T2  out  1  beat 2, high one cycle
T3  out  1  beat 3 (PC update), high one cycle
halted  out  1  sticky; set once HALT has retired
instr_count  out  16  retired-instruction counter, wraps

Behaviour:
- States: IDLE, FETCH, S_T0, S_T1, S_T2, S_T3, HALT. Encoding is free; outputs must behave as below.
- Reset (rst=1 at an edge), from any state:
  - state<=IDLE, PC<=RESET_PC, IR<=16'h0000, instr_count<=0, halted<=0.
  - mem_rd, T0..T3 are 0 in IDLE.
  - Any mem_ack pending at reset is discarded.
- IDLE -> FETCH unconditionally on the next edge.
- FETCH:
  - mem_rd=1, mem_addr=PC.
  - If mem_ack=1: IR<=mem_rdata at that edge and go to S_T0.
  - Otherwise stay in FETCH with mem_rd held high. No timeout.
  - mem_ack is ignored in every other state.
- S_T0 -> S_T1 -> S_T2 -> S_T3, one cycle each.
  - Tn=1 exactly during state S_Tn; otherwise 0. At most one of T0..T3 is high in any cycle.
  - T0..T3 are decoded from state and must be glitch-free: registered, or decoded from a one-hot state register.
  - IR and PC are stable from the S_T0 cycle through the S_T3 cycle.
- S_T3 exit:
  - instr_count<=instr_count+1, mod 2^16.
  - If IR[15:11]==HALT_OPCODE: go to HALT, halted<=1, PC unchanged (still points at the HALT word).
  - Else if pc_load=1: PC<=pc_target, go to FETCH.
  - Else: PC<=PC+1 (word addressing; 16'hFFFF wraps to 16'h0000), go to FETCH.
  - HALT takes priority over pc_load.
- HALT:
  - Absorbing: mem_rd=0, T0..T3=0, IR/PC/instr_count frozen, halted=1.
  - Left only by rst.
- Latency:
  - First mem_rd occurs 1 cycle after rst deasserts.
  - With zero-wait memory (ack in first FETCH cycle), one instruction takes 5 cycles: FETCH, T0, T1, T2, T3.
  - Each wait cycle adds 1.
- pc_load/pc_target outside S_T3 have no effect.

Test Plan:
- Reset then zero-wait ack, mem_rdata=16'h0A25 -> mem_rd high 1 cycle after rst falls with mem_addr=0000; IR=0A25 at next edge; T0,T1,T2,T3 pulse one cycle each in order; next FETCH has mem_addr=0001; instr_count=1.
- Delayed ack: hold mem_ack=0 for 3 FETCH cycles, then 1 with data 16'h1234 -> mem_rd high 4 cycles, mem_addr constant; IR=1234 only after the ack edge; no T pulses while waiting; spurious mem_ack during S_T1 does not change IR.
- Redirect: pc_load=1, pc_target=16'h0040 asserted during S_T2 only -> ignored, PC increments. Same values asserted during S_T3 -> next mem_addr=0040.
- HALT: mem_rdata=16'hF800 (opcode 11111) with pc_load=1 in S_T3 -> state HALT, halted=1, PC unchanged, instr_count incremented; mem_rd and T0..T3 stay 0 for 20 cycles; rst returns PC=RESET_PC, halted=0.
- Wrap: RESET_PC=16'hFFFF, one non-HALT instruction -> next mem_addr=0000. Preload instr_count to FFFF, or run 65536 instructions -> count wraps to 0000.
- Reset mid-operation: assert rst during FETCH with mem_ack=1, and separately during S_T1 -> next cycle IDLE; IR=0000, PC=RESET_PC, T0..T3=0; ack data not loaded; fetch restarts 1 cycle after rst deasserts.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory read bus between the fetch sequencer and instruction memory.
// The master drives the request and address; the slave returns ack and data.
interface fetch_sequencer_if;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;

   modport master (output mem_rd, mem_addr, input mem_ack, mem_rdata);
   modport slave  (input mem_rd, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch stage: reads one instruction word per cycle group into IR.
// Then emits beats T0..T3, advances or redirects PC, and stops on HALT.
module fetch_sequencer #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter logic [4:0]  HALT_OPCODE = 5'b11111
) (
   input  logic                      clk,
   input  logic                      rst,
   fetch_sequencer_if.master         mem,
   input  logic                      pc_load,
   input  logic [15:0]               pc_target,
   output logic [15:0]               IR,
   output logic [15:0]               PC,
   output logic                      T0,
   output logic                      T1,
   output logic                      T2,
   output logic                      T3,
   output logic                      halted,
   output logic [15:0]               instr_count
);

   typedef enum logic [6:0] {
      IDLE  = 7'b0000001,
      FETCH = 7'b0000010,
      S_T0  = 7'b0000100,
      S_T1  = 7'b0001000,
      S_T2  = 7'b0010000,
      S_T3  = 7'b0100000,
      HALT  = 7'b1000000
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] ir_q, ir_d;
   logic [15:0] cnt_q, cnt_d;
   logic        halted_q, halted_d;
   logic        mem_rd_q, mem_rd_d;
   logic [3:0]  beat_q, beat_d;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      cnt_d    = cnt_q;
      halted_d = halted_q;
      case (state_q)
         IDLE:  state_d = FETCH;
         FETCH: begin
            if (mem.mem_ack) begin
               ir_d    = mem.mem_rdata;
               state_d = S_T0;
            end
         end
         S_T0:  state_d = S_T1;
         S_T1:  state_d = S_T2;
         S_T2:  state_d = S_T3;
         S_T3: begin
            cnt_d = cnt_q + 16'd1;
            // HALT wins over a redirect; PC keeps pointing at the HALT word
            if (ir_q[15:11] == HALT_OPCODE) begin
               state_d  = HALT;
               halted_d = 1'b1;
            end else if (pc_load) begin
               pc_d    = pc_target;
               state_d = FETCH;
            end else begin
               pc_d    = pc_q + 16'd1;
               state_d = FETCH;
            end
         end
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they are glitch-free.
   always_comb begin
      mem_rd_d = (state_d == FETCH);
      beat_d   = {state_d == S_T3, state_d == S_T2, state_d == S_T1, state_d == S_T0};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         ir_q     <= 16'h0000;
         cnt_q    <= 16'h0000;
         halted_q <= 1'b0;
         mem_rd_q <= 1'b0;
         beat_q   <= 4'b0000;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         cnt_q    <= cnt_d;
         halted_q <= halted_d;
         mem_rd_q <= mem_rd_d;
         beat_q   <= beat_d;
      end
   end

   assign mem.mem_rd   = mem_rd_q;
   assign mem.mem_addr = pc_q;
   assign IR           = ir_q;
   assign PC           = pc_q;
   assign T0           = beat_q[0];
   assign T1           = beat_q[1];
   assign T2           = beat_q[2];
   assign T3           = beat_q[3];
   assign halted       = halted_q;
   assign instr_count  = cnt_q;

endmodule
